regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk and Reset_n; all state SHALL update on posedge Clk.
REQ-002 Clk  input  1  system clock, rising-edge active.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 ReqA  input  1  requester A write request, held until granted.
REQ-005 AddrA  input  5  requester A target register.
REQ-006 DataA  input  32  requester A write data.
REQ-007 GntA  output  1  requester A grant, one-cycle pulse.
REQ-008 ReqB / AddrB / DataB / GntB SHALL mirror REQ-004..007 for requester B.
REQ-009 ClearStart  input  1  request to zero registers 1..31.
REQ-010 ClearBusy  output  1  high while the clear sequence runs.
REQ-011 ClearDone  output  1  one-cycle pulse after the last clear write.
REQ-012 WriteRegister  output  5  regfile write address.
REQ-013 WriteData  output  32  regfile write data.
REQ-014 wEnable  output  1  regfile write enable.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 The FSM SHALL have three states: IDLE, WRITE and CLEAR.
REQ-017 In IDLE, a posedge with the clear-pending flag set SHALL move the FSM to CLEAR, taking priority over ReqA/ReqB.
REQ-018 Otherwise, in IDLE, a posedge with any Req high SHALL select a winner and move the FSM to WRITE.
REQ-019 In the WRITE cycle the block SHALL drive wEnable=1, WriteRegister=winner Addr, WriteData=winner Data and the winner's Gnt=1; the loser's Gnt SHALL be 0.
REQ-020 WRITE SHALL always last exactly one cycle and then return to IDLE; Req inputs SHALL be ignored during WRITE.
REQ-021 Latency: Req sampled at edge k gives Gnt/wEnable high between edges k and k+1, and the regfile writes at edge k+1; sustained throughput is one write per 2 cycles.
REQ-022 Handshake: a requester SHALL hold Req/Addr/Data stable until it samples its Gnt high at a posedge, and may then drop Req or present a new request.
REQ-023 Arbitration SHALL be round-robin: when both Req are high, the requester not granted last wins; a single requester always wins.
REQ-024 The last-grant pointer SHALL reset so that A wins the first contention.
REQ-025 Address 0 requests SHALL be granted and issued normally; the regfile enforces the hard zero.
REQ-026 A ClearStart high at a posedge in IDLE or WRITE SHALL set the clear-pending flag.
REQ-027 ClearStart SHALL be ignored while in CLEAR.
REQ-028 CLEAR SHALL issue 31 consecutive cycles of wEnable=1, WriteData=0, WriteRegister=1,2,...,31 from a 5-bit counter.
REQ-029 ClearBusy SHALL be 1 for exactly those 31 cycles, and no Gnt SHALL be issued during CLEAR.
REQ-030 After the WriteRegister=31 cycle, the block SHALL return to IDLE with ClearDone=1 for one cycle and ClearBusy=0; the pending flag SHALL be cleared on entry to CLEAR.
REQ-031 In IDLE with nothing to do, the block SHALL drive wEnable=0, GntA=GntB=0, and hold WriteRegister/WriteData at 0.
REQ-032 Requests pending when CLEAR ends SHALL be arbitrated on the first IDLE edge after ClearDone.
REQ-033 The round-robin pointer SHALL be unaffected by CLEAR.

Reset
REQ-034 Reset_n=0 SHALL immediately, without waiting for Clk, force IDLE, wEnable=0, GntA=GntB=0, ClearBusy=0, ClearDone=0, WriteRegister=0, WriteData=0, clear-pending=0, clear counter=0 and round-robin pointer to favour A.
REQ-035 Reset asserted mid-WRITE or mid-CLEAR SHALL abort the operation with no further writes; after release the block SHALL resume from IDLE on the first posedge.

Verification
REQ-036 ReqA=1, AddrA=2, DataA=42 -> next cycle wEnable=1, WriteRegister=2, WriteData=42, GntA=1; regfile reg 2 reads 42.
REQ-037 ReqA and ReqB both held high (AddrA=11/DataA=40, AddrB=12/DataB=42, new data after each grant) -> grants alternate A,B,A,B, with one write every 2 cycles and never both Gnt in one cycle.
REQ-038 Preload reg 5=7, then a ClearStart pulse -> ClearBusy high 31 cycles, WriteRegister 1..31 with WriteData=0, then ClearDone pulse; reg 5 reads 0 and ReqB raised mid-clear is granted only after ClearDone.
REQ-039 ClearStart during a WRITE cycle -> the WRITE completes (Gnt seen) and CLEAR starts on the next IDLE edge, ahead of a simultaneous ReqA.
REQ-040 Reset_n pulsed low at clear step 10 -> outputs go to 0 asynchronously, the counter restarts, and a subsequent ReqA=1, AddrA=3, DataA=15 writes reg 3=15 normally.
REQ-041 ReqB=1, AddrB=0, DataB=42 -> GntB=1 and wEnable=1 with WriteRegister=0; reg 0 still reads 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin grants and a
// background sequence that zeroes registers 1..31. All outputs are registered.
module regfile_write_arbiter (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ReqA,
  input  logic [4:0]  AddrA,
  input  logic [31:0] DataA,
  output logic        GntA,
  input  logic        ReqB,
  input  logic [4:0]  AddrB,
  input  logic [31:0] DataB,
  output logic        GntB,
  input  logic        ClearStart,
  output logic        ClearBusy,
  output logic        ClearDone,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        wEnable
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  typedef struct packed {
    logic        gnt_a;
    logic        gnt_b;
    logic        we;
    logic        busy;
    logic        done;
    logic [4:0]  addr;
    logic [31:0] data;
  } out_t;

  state_t     state, state_d;
  out_t       out_q, out_d;
  logic       prio_b, prio_b_d;   // 1: B wins the next contention
  logic       pend, pend_d;
  logic [4:0] cnt, cnt_d;
  logic       pick_b;

  assign pick_b = ReqB && (!ReqA || prio_b);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      out_q  <= '0;
      prio_b <= 1'b0;
      pend   <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      out_q  <= out_d;
      prio_b <= prio_b_d;
      pend   <= pend_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pend) state_d = CLEAR;
               else if (ReqA || ReqB) state_d = WRITE;
      WRITE:   state_d = IDLE;
      CLEAR:   if (cnt == 5'd31) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes the values the outputs take for the cycle after this edge.
  always_comb begin
    out_d    = '0;
    prio_b_d = prio_b;
    cnt_d    = cnt;
    pend_d   = pend | (ClearStart && state != CLEAR);
    case (state)
      IDLE: begin
        if (pend) begin
          pend_d     = 1'b0;
          cnt_d      = 5'd1;
          out_d.we   = 1'b1;
          out_d.busy = 1'b1;
          out_d.addr = 5'd1;
        end else if (ReqA || ReqB) begin
          out_d.we    = 1'b1;
          out_d.gnt_a = !pick_b;
          out_d.gnt_b = pick_b;
          out_d.addr  = pick_b ? AddrB : AddrA;
          out_d.data  = pick_b ? DataB : DataA;
          prio_b_d    = !pick_b;
        end
      end
      CLEAR: begin
        if (cnt == 5'd31) begin
          cnt_d      = '0;
          out_d.done = 1'b1;
        end else begin
          cnt_d      = cnt + 5'd1;
          out_d.we   = 1'b1;
          out_d.busy = 1'b1;
          out_d.addr = cnt + 5'd1;
        end
      end
      default: ;
    endcase
  end

  assign GntA          = out_q.gnt_a;
  assign GntB          = out_q.gnt_b;
  assign wEnable       = out_q.we;
  assign ClearBusy     = out_q.busy;
  assign ClearDone     = out_q.done;
  assign WriteRegister = out_q.addr;
  assign WriteData     = out_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// attached to the write port.
module tb_regfile_write_arbiter;

  logic        Clk, Reset_n;
  logic        ReqA, ReqB, GntA, GntB;
  logic [4:0]  AddrA, AddrB, WriteRegister;
  logic [31:0] DataA, DataB, WriteData;
  logic        ClearStart, ClearBusy, ClearDone, wEnable;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .GntA(GntA),
    .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .GntB(GntB),
    .ClearStart(ClearStart), .ClearBusy(ClearBusy), .ClearDone(ClearDone),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .wEnable(wEnable)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if (wEnable && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   {31'd0, wEnable}, 32'd0);
    chk({tag, ".gnt"},  {30'd0, GntA, GntB}, 32'd0);
    chk({tag, ".addr"}, {27'd0, WriteRegister}, 32'd0);
    chk({tag, ".data"}, WriteData, 32'd0);
    chk({tag, ".busy"}, {30'd0, ClearBusy, ClearDone}, 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic ga, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},   {31'd0, wEnable}, 32'd1);
    chk({tag, ".gnt"},  {30'd0, GntA, GntB}, ga ? 32'd2 : 32'd1);
    chk({tag, ".addr"}, {27'd0, WriteRegister}, {27'd0, a});
    chk({tag, ".data"}, WriteData, d);
  endtask

  logic [4:0]  rr_addr [4] = '{5'd11, 5'd12, 5'd11, 5'd12};
  logic [31:0] rr_data [4] = '{32'd40, 32'd42, 32'd41, 32'd43};

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    ReqA = 0; ReqB = 0; AddrA = 0; AddrB = 0; DataA = 0; DataB = 0; ClearStart = 0;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1 chk_idle("reset");
    step();
    Reset_n = 1'b1;
    step();
    chk_idle("post_reset");

    // Contention: A first after reset, then strict alternation
    ReqA = 1; AddrA = 5'd11; DataA = 32'd40;
    ReqB = 1; AddrB = 5'd12; DataB = 32'd42;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_write("rr", (i % 2) == 0, rr_addr[i], rr_data[i]);
      if ((i % 2) == 0) DataA = 32'd41; else DataB = 32'd43;
      step();
      chk("rr.gap_we", {31'd0, wEnable}, 32'd0);
    end
    ReqA = 0; ReqB = 0;
    chk("rr.rf11", rf[11], 32'd41);
    chk("rr.rf12", rf[12], 32'd43);

    // Single write from A
    ReqA = 1; AddrA = 5'd2; DataA = 32'd42;
    step();
    chk_write("wa", 1'b1, 5'd2, 32'd42);
    ReqA = 0;
    step();
    chk("wa.rf2", rf[2], 32'd42);
    chk_idle("wa.idle");

    // Address 0 passes through the arbiter
    ReqB = 1; AddrB = 5'd0; DataB = 32'd42;
    step();
    chk_write("wb0", 1'b0, 5'd0, 32'd42);
    ReqB = 0;
    step();

    // Preload reg 5, then clear with ReqB arriving mid-clear
    ReqA = 1; AddrA = 5'd5; DataA = 32'd7;
    step();
    chk_write("pre5", 1'b1, 5'd5, 32'd7);
    ReqA = 0;
    step();
    chk("pre5.rf", rf[5], 32'd7);
    ClearStart = 1;
    step();
    ClearStart = 0;
    chk("clr.arm_busy", {31'd0, ClearBusy}, 32'd0);
    step();
    for (int i = 1; i <= 31; i++) begin
      chk("clr.busy", {31'd0, ClearBusy}, 32'd1);
      chk("clr.we",   {31'd0, wEnable}, 32'd1);
      chk("clr.addr", {27'd0, WriteRegister}, i);
      chk("clr.data", WriteData, 32'd0);
      chk("clr.gnt",  {30'd0, GntA, GntB}, 32'd0);
      if (i == 10) begin ReqB = 1; AddrB = 5'd9; DataB = 32'd99; end
      step();
    end
    chk("clr.done", {31'd0, ClearDone}, 32'd1);
    chk("clr.end_busy", {31'd0, ClearBusy}, 32'd0);
    chk("clr.end_we", {31'd0, wEnable}, 32'd0);
    chk("clr.end_gnt", {30'd0, GntA, GntB}, 32'd0);
    chk("clr.rf5", rf[5], 32'd0);
    chk("clr.rf2", rf[2], 32'd0);
    step();
    chk_write("after_clr", 1'b0, 5'd9, 32'd99);
    chk("after_clr.done", {31'd0, ClearDone}, 32'd0);
    ReqB = 0;
    step();

    // ClearStart during WRITE: clear beats a simultaneous ReqA
    ReqA = 1; AddrA = 5'd4; DataA = 32'd5;
    step();
    chk_write("wc", 1'b1, 5'd4, 32'd5);
    ClearStart = 1;
    step();
    ClearStart = 0;
    AddrA = 5'd6; DataA = 32'd8;
    chk("wc.gap_we", {31'd0, wEnable}, 32'd0);
    step();
    chk("wc.busy", {31'd0, ClearBusy}, 32'd1);
    chk("wc.gnt", {30'd0, GntA, GntB}, 32'd0);
    chk("wc.addr", {27'd0, WriteRegister}, 32'd1);
    ReqA = 0;

    // Asynchronous reset at clear step 10
    for (int i = 0; i < 9; i++) step();
    chk("rst.step10", {27'd0, WriteRegister}, 32'd10);
    #2 Reset_n = 1'b0;
    #1 chk_idle("rst.async");
    step();
    chk_idle("rst.hold");
    Reset_n = 1'b1;
    ReqA = 1; AddrA = 5'd3; DataA = 32'd15;
    step();
    chk_write("rst.wa", 1'b1, 5'd3, 32'd15);
    chk("rst.busy", {31'd0, ClearBusy}, 32'd0);
    ReqA = 0;
    step();
    chk("rst.rf3", rf[3], 32'd15);

    // Clear counter restarts from 1
    ClearStart = 1;
    step();
    ClearStart = 0;
    step();
    chk("rst.clr_addr", {27'd0, WriteRegister}, 32'd1);
    chk("rst.clr_busy", {31'd0, ClearBusy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
